// File: rtl/alu_arb_seq_pkg.sv
// alu_arb_seq_pkg: opcodes, status bit positions and FSM states shared by the ALU arbiter.
package alu_arb_seq_pkg;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SBB = 3'b111;
  localparam int ST_C = 5;
  localparam int ST_Z = 4;
  localparam int ST_N = 3;
  localparam int ST_V = 2;
  localparam int ST_P = 1;
  localparam int ST_AF = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  function automatic logic op_valid(input logic [2:0] op);
    return op == OP_INC || op == OP_DEC || op[2];
  endfunction
endpackage

// File: rtl/alu_arb_seq_arith.sv
// alu_arith_unit: combinational INC/DEC/ADD/ADC/SUB/SBB with {C,Z,N,V,P,Af} flags.
module alu_arith_unit
  import alu_arb_seq_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic [2:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic [Width-1:0] result,
  output logic [5:0]       status
);
  localparam logic [Width:0] One = 1;
  logic [Width:0] xa, xb, xc, full;
  logic [Width-1:0] r;
  logic [4:0] nib;
  logic ok, v, sa, sb, sr;
  assign xa = {1'b0, a};
  assign xb = {1'b0, b};
  assign xc = {{Width{1'b0}}, cin};
  assign full = op == OP_INC ? xa + One :
                op == OP_DEC ? xa - One :
                op == OP_ADD ? xa + xb :
                op == OP_ADC ? xa + xb + xc :
                op == OP_SUB ? xa - xb :
                op == OP_SBB ? xa - xb - xc : '0;
  assign r = full[Width-1:0];
  assign ok = op_valid(op);
  assign sa = a[Width-1];
  assign sb = b[Width-1];
  assign sr = r[Width-1];
  // op[1] separates the subtract pair (11x) from the add pair (10x)
  assign v = (op == OP_INC || op == OP_DEC) ? sa != sr :
             op[1] ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
  assign nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign result = ok ? r : '0;
  assign status = ok ? {full[Width], ~|r, sr, v, ~^r, nib[4]} : 6'b0;
endmodule

// File: rtl/alu_arb_seq.sv
// alu_arb_seq: two-requester round-robin front end sharing one ALU, one operation in flight.
module alu_arb_seq
  import alu_arb_seq_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [Width-1:0] req_a0,
  input  logic [Width-1:0] req_b0,
  input  logic [Width-1:0] req_a1,
  input  logic [Width-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [Width-1:0] rsp_result,
  output logic [5:0]       rsp_status,
  output logic [1:0]       carry_q
);
  state_t state;
  logic last_grant, gnt, id, cin;
  logic [2:0] op;
  logic [Width-1:0] a, b, result;
  logic [5:0] status;
  assign gnt = &req_valid ? ~last_grant : req_valid[1];
  // gated by rst so nothing looks acceptable while reset is held
  assign req_ready = (state == S_IDLE && !rst && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  alu_arith_unit #(.Width(Width)) u_arith (
    .op(op), .a(a), .b(b), .cin(cin), .result(result), .status(status)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last_grant <= 1'b1;
      id <= 1'b0;
      cin <= 1'b0;
      op <= 3'b0;
      a <= '0;
      b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_status <= 6'b0;
      carry_q <= 2'b00;
    end else begin
      case (state)
        S_IDLE: if (|(req_valid & req_ready)) begin
          op <= gnt ? req_op1 : req_op0;
          a <= gnt ? req_a1 : req_a0;
          b <= gnt ? req_b1 : req_b0;
          cin <= carry_q[gnt];
          id <= gnt;
          last_grant <= gnt;
          state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_result <= result;
          rsp_status <= status;
          rsp_id <= id;
          rsp_valid <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          carry_q[rsp_id] <= rsp_status[ST_C];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arb_seq.sv
// tb_alu_arb_seq: randomized and directed checks of alu_arb_seq against an arithmetic reference model.
module tb_alu_arb_seq;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_ready, carry_q;
  logic [2:0] req_op0 = 0, req_op1 = 0;
  logic [15:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0, rsp_result;
  logic rsp_valid, rsp_ready = 0, rsp_id;
  logic [5:0] rsp_status;
  logic [1:0] m_carry = 0;
  logic m_last = 1;
  int n_chk = 0, n_pass = 0;

  alu_arb_seq #(.Width(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_status(rsp_status), .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [21:0] ref_alu(input logic [2:0] op, input logic [15:0] a, b, input logic cin);
    int ai, bi, ci, full, sa, sb, tr;
    logic [15:0] res;
    logic c, v;
    ai = a; bi = b; ci = cin;
    sa = a[15] ? ai - 65536 : ai;
    sb = b[15] ? bi - 65536 : bi;
    case (op)
      3'b001: begin full = ai + 1; tr = 0; end
      3'b011: begin full = ai - 1; tr = 0; end
      3'b100: begin full = ai + bi; tr = sa + sb; end
      3'b101: begin full = ai + bi + ci; tr = sa + sb + ci; end
      3'b110: begin full = ai - bi; tr = sa - sb; end
      3'b111: begin full = ai - bi - ci; tr = sa - sb - ci; end
      default: return 22'd0;
    endcase
    res = 16'(full);
    c = full < 0 || full > 65535;
    v = (op == 3'b001 || op == 3'b011) ? a[15] != res[15] : (tr > 32767 || tr < -32768);
    return {res, c, res == 16'd0, res[15], v, ~^res, ((ai % 16) + (bi % 16) + ci) > 15};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_txn(input logic [1:0] v, input logic [2:0] o0, o1,
                         input logic [15:0] x0, y0, x1, y1, input int stall);
    logic g;
    logic [21:0] e;
    g = (v == 2'b11) ? ~m_last : v[1];
    e = g ? ref_alu(o1, x1, y1, m_carry[g]) : ref_alu(o0, x0, y0, m_carry[g]);
    @(posedge clk); #1;
    req_valid = v; req_op0 = o0; req_op1 = o1;
    req_a0 = x0; req_b0 = y0; req_a1 = x1; req_b1 = y1; rsp_ready = 0;
    #1 check("grant", req_ready, g ? 2'b10 : 2'b01);
    @(posedge clk); #1 req_valid = 0;
    #1 check("exec_quiet", {rsp_valid, req_ready}, 3'b000);
    @(posedge clk); #2;
    check("latency", rsp_valid, 1);
    check("rsp_id", rsp_id, g);
    check("result", rsp_result, e[21:6]);
    check("status", rsp_status, e[5:0]);
    for (int i = 0; i < stall; i++) begin
      req_valid = v;
      @(posedge clk); #2;
      check("hold", {rsp_valid, rsp_id, rsp_result, rsp_status, req_ready}, {1'b1, g, e, 2'b00});
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0; req_valid = 0;
    #1 check("rsp_done", rsp_valid, 0);
    m_carry[g] = e[5];
    m_last = g;
    check("carry_q", carry_q, m_carry);
  endtask

  initial begin
    #3 check("reset_out", {rsp_valid, rsp_id, rsp_result, rsp_status, req_ready, carry_q}, 0);
    @(posedge clk); #1 rst = 0;
    // round-robin with both requesters always valid: ids 0,1,0,1
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 3'b100, 3'b100, rnd16(), rnd16(), rnd16(), rnd16(), 0);
    run_txn(2'b01, 3'b100, 3'b000, 16'h7FFF, 16'h0001, 0, 0, 0);
    check("ex_result", rsp_result, 16'h8000);
    check("ex_status", rsp_status, 6'b001101);
    run_txn(2'b01, 3'b100, 3'b000, 16'hFFFF, 16'h0001, 0, 0, 0);
    check("chain_c", carry_q[0], 1);
    run_txn(2'b01, 3'b101, 3'b000, 16'h0000, 16'h0000, 0, 0, 0);
    check("chain_res", rsp_result, 16'h0001);
    run_txn(2'b10, 3'b000, 3'b100, 0, 0, 16'hFFFF, 16'h0001, 0);
    run_txn(2'b10, 3'b000, 3'b010, 0, 0, 16'h1234, 16'h0000, 0);
    check("inv_carry", carry_q[1], 0);
    run_txn(2'b11, 3'b110, 3'b111, rnd16(), rnd16(), rnd16(), rnd16(), 5);
    for (int i = 0; i < 40; i++)
      run_txn(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              rnd16(), rnd16(), rnd16(), rnd16(), $urandom_range(0, 3));
    run_txn(2'b10, 3'b000, 3'b001, 0, 0, 16'hFFFF, 0, 0);
    // reset in the middle of EXEC discards the op
    @(posedge clk); #1 req_valid = 2'b01; req_op0 = 3'b100; req_a0 = 16'h0001; req_b0 = 16'h0002;
    @(posedge clk); #1 rst = 1; req_valid = 2'b11;
    #1 check("rst_exec", {rsp_valid, rsp_id, rsp_result, rsp_status, req_ready, carry_q}, 0);
    @(posedge clk); #1 rst = 0; req_valid = 0;
    m_carry = 0; m_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2 check("no_rsp", rsp_valid, 0);
    end
    run_txn(2'b11, 3'b101, 3'b100, 16'h000F, 16'h0001, 16'h1111, 16'h2222, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
